// File: rtl/inst_encoder.sv
// inst_encoder: packs RISC-V opcode/register/funct/immediate fields into a 32-bit word.
// Latency: word accepted at edge k is presented on out_* after edge k+1 (two elastic stages).
// Backpressure: in_ready = !s1_valid || !out_valid || out_ready; no input is ever dropped.
// Optional feature: define INST_ENC_RANGE_CHECK_EN to drive out_err from the immediate range checks.
module inst_encoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] enc_count
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_CSR = 3'd7
  } fmt_e;

  logic        s1_valid;
  logic [31:0] s1_inst;
  logic        s1_err;
  logic        s1_ready;
  logic        s2_ready;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic [4:0]  csr_src;

  // Each stage may load when it is empty or its occupant is leaving this cycle.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  // CSR immediate forms (funct3[2]=1) carry a 5-bit zimm in the rs1 slot.
  assign csr_src = in_funct3[2] ? in_imm[4:0] : in_rs1;

  // Scatter fields into the format-specific bit positions.
  always_comb begin
    enc_inst = {25'd0, in_opcode};
    case (fmt_e'(in_fmt))
      FMT_R:   enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I:   enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_ISH: enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S:   enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B:   enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
      FMT_U:   enc_inst = {in_imm[31:12], in_rd, in_opcode};
      FMT_J:   enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      FMT_CSR: enc_inst = {in_funct7, in_rs2, csr_src, in_funct3, in_rd, in_opcode};
      default: enc_inst = {25'd0, in_opcode};
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // Flag immediates whose significant bits do not fit the format's field.
  always_comb begin
    enc_err = 1'b0;
    case (fmt_e'(in_fmt))
      FMT_I,
      FMT_S:   enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_ISH: enc_err = |in_imm[31:5];
      FMT_B:   enc_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
      FMT_U:   enc_err = |in_imm[11:0];
      FMT_J:   enc_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      FMT_CSR: enc_err = in_funct3[2] && (|in_imm[31:5]);
      default: enc_err = 1'b0;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  // Stage 1: capture the encoded word and its error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inst  <= 32'd0;
      s1_err   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_inst <= enc_inst;
        s1_err  <= enc_err;
      end
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_err   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= s1_inst;
        out_err  <= s1_err;
      end else begin
        out_err  <= 1'b0;
      end
    end
  end

  // Count delivered words, sticking at the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (out_valid && out_ready && (enc_count != {CNT_WIDTH{1'b1}})) begin
      enc_count <= enc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed vectors plus randomized traffic against a queue model.
// Small counter width so saturation is reached quickly.
// Honors INST_ENC_RANGE_CHECK_EN to decide whether out_err is expected to fire.
module tb_inst_encoder;

  localparam int CW = 4;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] enc_count;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  logic [31:0]   cyc = 0;
  logic [CW-1:0] cnt_m;

  inst_encoder #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp acceptances.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic fld_t mk(input int fmt, input int op, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7, input logic [31:0] imm);
    fld_t f;
    f.fmt = fmt[2:0]; f.op = op[6:0]; f.rd = rd[4:0]; f.rs1 = rs1[4:0];
    f.rs2 = rs2[4:0]; f.f3 = f3[2:0]; f.f7 = f7[6:0]; f.imm = imm;
    return f;
  endfunction

  // Reference: place fields with shifts/masks, judge ranges as signed integer intervals.
  function automatic exp_t model(input fld_t f);
    exp_t e;
    logic [31:0] op, rd, rs1, rs2, f3, f7, u;
    int s;
    op = 32'(f.op); rd = 32'(f.rd); rs1 = 32'(f.rs1); rs2 = 32'(f.rs2);
    f3 = 32'(f.f3); f7 = 32'(f.f7); u = f.imm; s = $signed(f.imm);
    e.acc = 0;
    e.err = 1'b0;
    case (f.fmt)
      3'd0: e.inst = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        e.inst = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e.err  = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        e.inst = (f7 << 25) | ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e.err  = u > 31;
      end
      3'd3: begin
        e.inst = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((u & 31) << 7) | op;
        e.err  = (s < -2048) || (s > 2047);
      end
      3'd4: begin
        e.inst = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
               | (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | op;
        e.err  = (u % 2 != 0) || (s < -4096) || (s > 4095);
      end
      3'd5: begin
        e.inst = (u & 32'hFFFFF000) | (rd << 7) | op;
        e.err  = (u % 4096) != 0;
      end
      3'd6: begin
        e.inst = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
               | (((u >> 12) & 255) << 12) | (rd << 7) | op;
        e.err  = (u % 2 != 0) || (s < -1048576) || (s > 1048575);
      end
      default: begin
        e.inst = (f7 << 25) | (rs2 << 20) | ((f.f3[2] ? (u & 31) : rs1) << 15)
               | (f3 << 12) | (rd << 7) | op;
        e.err  = f.f3[2] && (u > 31);
      end
    endcase
    e.err = e.err && ERR_ON;
    return e;
  endfunction

  // One cycle: drive at negedge, check against model, advance to the next negedge.
  task automatic step(input logic v, input fld_t f, input logic ordy, output logic acc);
    exp_t e;
    logic exp_vld;
    in_valid = v; in_fmt = f.fmt; in_opcode = f.op; in_rd = f.rd; in_rs1 = f.rs1;
    in_rs2 = f.rs2; in_funct3 = f.f3; in_funct7 = f.f7; in_imm = f.imm; out_ready = ordy;
    #1;
    exp_vld = 1'b0;
    if (q.size() > 0) exp_vld = (q[0].acc < cyc);
    check("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    check("enc_count", 32'(enc_count), 32'(cnt_m));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_inst", out_inst, e.inst);
        check("out_err", 32'(out_err), 32'(e.err));
        if (cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
      end
    end
    acc = v && in_ready;
    if (acc) begin
      e = model(f);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] b[8];
    b = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'hFFFFF000, 32'd31, 32'd32};
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 63);
      2: return 32'(-$urandom_range(0, 5000));
      3: return b[$urandom_range(0, 7)];
      4: return $urandom & 32'hFFFFF000;
      default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
  endfunction

  fld_t idle, f;
  fld_t w[3];
  logic a;
  int   k;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_m = '0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // addi x1,x0,5
    step(1'b1, mk(1, 'h13, 1, 0, 0, 0, 0, 5), 1'b1, a);
    check("addi_acc", 32'(a), 32'd1);
    step(1'b0, idle, 1'b1, a);
    check("addi_vld", 32'(out_valid), 32'd1);
    check("addi_inst", out_inst, 32'h00500093);
    check("addi_err", 32'(out_err), 32'd0);
    step(1'b0, idle, 1'b1, a);
    check("addi_cnt", 32'(enc_count), 32'd1);

    // beq x1,x2,-4
    step(1'b1, mk(4, 'h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC), 1'b1, a);
    step(1'b0, idle, 1'b1, a);
    check("beq_inst", out_inst, 32'hFE208EE3);
    check("beq_err", 32'(out_err), 32'd0);
    step(1'b0, idle, 1'b1, a);

    // lui x5 legal then with stray low bits, back to back
    step(1'b1, mk(5, 'h37, 5, 0, 0, 0, 0, 32'h12345000), 1'b1, a);
    step(1'b1, mk(5, 'h37, 5, 0, 0, 0, 0, 32'h12345001), 1'b1, a);
    check("lui_inst", out_inst, 32'h123452B7);
    check("lui_err", 32'(out_err), 32'd0);
    step(1'b0, idle, 1'b1, a);
    check("lui_bad_inst", out_inst, 32'h123452B7);
    check("lui_bad_err", 32'(out_err), 32'(ERR_ON));
    step(1'b0, idle, 1'b1, a);

    // addi with out-of-range immediate 2048
    step(1'b1, mk(1, 'h13, 1, 0, 0, 0, 0, 2048), 1'b1, a);
    step(1'b0, idle, 1'b1, a);
    check("addi2048_inst", out_inst, 32'h80000093);
    check("addi2048_err", 32'(out_err), 32'(ERR_ON));
    step(1'b0, idle, 1'b1, a);

    // Backpressure: 3 words offered with the consumer stalled for 5 cycles
    w[0] = mk(0, 'h33, 3, 4, 5, 0, 0, 0);
    w[1] = mk(1, 'h13, 6, 7, 0, 1, 0, 32'hFFFFFFFF);
    w[2] = mk(6, 'h6F, 1, 0, 0, 0, 0, 32'h00000800);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w[k], 1'b0, a);
      if (a) k++;
    end
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 20 && (k < 3 || q.size() > 0); i++) begin
      step(k < 3, w[(k < 3) ? k : 2], 1'b1, a);
      if (a) k++;
    end
    check("bp_all_in", 32'(k), 32'd3);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Reset with two words in flight
    step(1'b1, w[0], 1'b0, a);
    step(1'b1, w[1], 1'b0, a);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(enc_count), 32'd0);
    q.delete();
    cnt_m = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, w[2], 1'b1, a);
    check("post_rst_acc", 32'(a), 32'd1);
    step(1'b0, idle, 1'b1, a);
    check("post_rst_vld", 32'(out_valid), 32'd1);
    step(1'b0, idle, 1'b1, a);

    // Randomized traffic; the counter saturates along the way
    for (int i = 0; i < 600; i++) begin
      f = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, rand_imm());
      step(($urandom_range(0, 3) != 0), f, ($urandom_range(0, 3) != 0), a);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, idle, 1'b1, a);
    check("final_drained", 32'(q.size()), 32'd0);
    check("final_cnt_sat", 32'(enc_count), 32'({CW{1'b1}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

- Streaming RISC-V instruction encoder: builds a 32-bit instruction word from opcode, register, function and immediate fields.
- Performs the inverse of immediate extraction: scatters the immediate into the format-specific bit positions and range-checks it.
- Sits between the debug/instruction-injection controller and the core's instruction-injection port.
- Two-stage elastic pipeline with valid/ready handshakes on both sides and an output-word counter.

## Interface
- CNT_WIDTH, 16, width of the encoded-word counter
- clk  in  1  clock, all state rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  format: 0=R, 1=I, 2=I* (shift), 3=S, 4=B, 5=U, 6=J, 7=CSR
- in_opcode  in  7  inst[6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R, I*); CSR address high bits (CSR)
- in_imm  in  32  immediate, byte-offset form, two's complement
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_inst  out  32  encoded instruction
- out_err  out  1  immediate not representable in in_fmt
- enc_count  out  CNT_WIDTH  output handshakes since reset, saturating

## Operation
- Stage 1 registers the field mux and range-check result. Stage 2 is the output register.
- Each stage uses the rule: ready = !valid || downstream ready. Therefore in_ready = !s1_valid || !s2_valid || out_ready.
- Common fields: inst[6:0]=opcode.
  - rd at [11:7] for R/I/I*/U/J/CSR.
  - funct3 at [14:12] for all formats except U and J.
  - rs1 at [19:15] and rs2 at [24:20] where the format has them.
- R: inst[31:25]=funct7.
- I: inst[31:20]=imm[11:0]. Error unless imm[31:11] all equal.
- I*: inst[31:25]=funct7, inst[24:20]=imm[4:0]. Error unless imm[31:5]==0.
- S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]. Error as I.
- B: {inst[31],inst[7],inst[30:25],inst[11:8]}=imm[12:1]. Error unless imm[0]==0 and imm[31:12] all equal.
- U: inst[31:12]=imm[31:12]. Error unless imm[11:0]==0.
- J: {inst[31],inst[19:12],inst[20],inst[30:21]}=imm[20:1]. Error unless imm[0]==0 and imm[31:20] all equal.
- CSR:
  - inst[31:20]={funct7,rs2}.
  - inst[19:15]=funct3[2] ? imm[4:0] : rs1.
  - Error if funct3[2] and imm[31:5]!=0.
- On error the word is still emitted with the truncated bits, and out_err=1 travels with that word.
- enc_count increments on each out_valid&&out_ready; it holds at 2^CNT_WIDTH-1 once saturated.

## Timing
- Reset (async, rst_n low):
  - s1_valid, out_valid, out_err and enc_count clear immediately.
  - out_inst clears to 0.
  - in_ready=1 once reset is released.
- Latency: a word accepted at edge k is on out_* after edge k+1. This holds when stage 2 is empty or draining.
- Throughput: one word per cycle with out_ready held high.
- out_inst and out_err stay stable while out_valid && !out_ready.
- in_ready falls only when both stages are full and out_ready=0. The input is never dropped.
- Simultaneous accept and output handshake in one cycle: both occur, and the pipeline occupancy is unchanged.
- Reset mid-operation: in-flight words are discarded and are not counted.
- in_* values are ignored when in_valid=0.

## Configuration
- INST_ENC_RANGE_CHECK_EN defined: range checks as above drive out_err.
- Not defined:
  - Check logic is omitted and out_err is tied to 0.
  - Encoding and truncation are identical.

## Test plan
- addi x1,x0,5 (fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5) -> out_inst=0x00500093, out_err=0, out_valid after the second edge, enc_count=1 after handshake.
- beq x1,x2,-4 (fmt=4, opcode=0x63, rs1=1, rs2=2, imm=0xFFFFFFFC) -> 0xFE208EE3, out_err=0.
- lui x5,0x12345 (fmt=5, opcode=0x37, rd=5, imm=0x12345000) -> 0x123452B7. Same fields with imm=0x12345001 -> same word, out_err=1.
- addi imm=2048 -> inst[31:20]=0x800, out_err=1. Repeat without the macro -> out_err=0.
- out_ready=0 for 5 cycles while 3 words are offered back-to-back -> 2 accepted, in_ready=0 after that. On release, all 3 emerge in order with none lost.
- rst_n low for 1 cycle with 2 words in flight -> out_valid=0 and enc_count=0 immediately. The next accepted word appears 2 edges later.
